// File: rtl/rps_n.sv
// rps_n: registered round-robin arbiter with a rotating priority pointer.
//
// Each enabled cycle the requester vector is scanned circularly starting at
// the priority pointer (count). The first asserted request wins, its grant is
// registered, and the pointer moves to the slot just past the winner, so the
// winner has the lowest priority in the next arbitration.
//
// Optional feature, selected at build time by the macro RPS_LOCK_EN:
//   defined   - a lock input is present; the current holder keeps the grant
//               (pointer frozen) while it asserts both lock and its request.
//   undefined - no lock port and no hold logic; arbitration every enabled cycle.
//
// Parameters:
//   NUM_REQ   number of requesters, power of two, 2..64
//   CW        derived pointer/index width, $clog2(NUM_REQ)
//
// Ports:
//   clock      in   single clock, all state updates on the rising edge
//   reset_n    in   synchronous active-low reset
//   en         in   arbitration enable; low drops the grant and holds count
//   req        in   request vector, bit i belongs to requester i
//   lock       in   holder asks to retain its grant (RPS_LOCK_EN only)
//   gnt        out  registered grant, one-hot or zero
//   gnt_valid  out  registered, high when gnt is nonzero
//   gnt_idx    out  registered binary index of the granted requester, 0 if none
//   count      out  registered priority pointer for the next arbitration
//
// All outputs come straight from flops; there is no input-to-output path.

module rps_n #(
  parameter int unsigned NUM_REQ = 8,
  localparam int unsigned CW = $clog2(NUM_REQ)
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               en,
  input  logic [NUM_REQ-1:0] req,
`ifdef RPS_LOCK_EN
  input  logic               lock,
`endif
  output logic [NUM_REQ-1:0] gnt,
  output logic               gnt_valid,
  output logic [CW-1:0]      gnt_idx,
  output logic [CW-1:0]      count
);

  // Registered state.
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic               valid_q, valid_d;
  logic [CW-1:0]      idx_q, idx_d;
  logic [CW-1:0]      count_q, count_d;

  // Result of the circular scan.
  logic               win_found;
  logic [CW-1:0]      win_idx;
  logic [CW-1:0]      cand;

  // Circular priority scan starting at count_q. NUM_REQ is a power of two,
  // so adding the offset in CW bits wraps modulo NUM_REQ for free. The
  // found flag keeps the first (highest-priority) hit.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = count_q + CW'(k);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

`ifdef RPS_LOCK_EN
  // Hold only applies to an existing grant; lock with no grant is ignored.
  // Because the holder's request bit is part of the condition, dropping the
  // request releases the lock and normal arbitration happens the same cycle.
  logic hold;
  assign hold = en && lock && valid_q && req[idx_q];
`endif

  // Next-state selection. Defaults describe the idle result: no grant and
  // the pointer held.
  always_comb begin
    gnt_d   = '0;
    valid_d = 1'b0;
    idx_d   = '0;
    count_d = count_q;
`ifdef RPS_LOCK_EN
    if (hold) begin
      // Pointer already sits at holder+1, so it stays put during the hold.
      gnt_d   = gnt_q;
      valid_d = valid_q;
      idx_d   = idx_q;
    end else
`endif
    if (en && win_found) begin
      gnt_d[win_idx] = 1'b1;
      valid_d        = 1'b1;
      idx_d          = win_idx;
      count_d        = win_idx + CW'(1);
    end
  end

  // Reset overrides every input. Lock state needs no flop of its own: it is
  // implied by the registered grant, so clearing the grant clears the lock.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      gnt_q   <= '0;
      valid_q <= 1'b0;
      idx_q   <= '0;
      count_q <= '0;
    end else begin
      gnt_q   <= gnt_d;
      valid_q <= valid_d;
      idx_q   <= idx_d;
      count_q <= count_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_valid = valid_q;
  assign gnt_idx   = idx_q;
  assign count     = count_q;

endmodule

// File: tb/tb_rps_n.sv
// Self-checking bench for rps_n with NUM_REQ = 8. A spec-level model computes
// the expected grant and pointer each cycle; a negedge process compares the
// DUT against it and against hand-computed literals pinned by the directed
// sequence. Build with or without RPS_LOCK_EN.

module tb_rps_n;
  localparam int N = 8;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic         en = 1'b0;
  logic [N-1:0] req = '0;
`ifdef RPS_LOCK_EN
  logic         lock = 1'b0;
`endif
  logic [N-1:0] gnt;
  logic         gnt_valid;
  logic [2:0]   gnt_idx;
  logic [2:0]   count;

  rps_n #(.NUM_REQ(N)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .en       (en),
    .req      (req),
`ifdef RPS_LOCK_EN
    .lock     (lock),
`endif
    .gnt      (gnt),
    .gnt_valid(gnt_valid),
    .gnt_idx  (gnt_idx),
    .count    (count)
  );

  always #5 clock = ~clock;

  // Behavioural model: integer holder index, validity and pointer.
  int m_valid = 0;
  int m_idx   = 0;
  int m_count = 0;

  always @(posedge clock) begin
    int found;
    if (!reset_n) begin
      m_valid = 0; m_idx = 0; m_count = 0;
    end else if (!en) begin
      m_valid = 0; m_idx = 0;
    end
`ifdef RPS_LOCK_EN
    else if (lock && m_valid == 1 && req[m_idx]) begin
      // holder keeps grant, pointer unchanged
    end
`endif
    else begin
      found = 0;
      for (int k = 0; k < N; k++) begin
        if (found == 0 && req[(m_count + k) % N]) begin
          found = 1;
          m_idx = (m_count + k) % N;
        end
      end
      m_valid = found;
      if (found == 1) m_count = (m_idx + 1) % N;
      else m_idx = 0;
    end
  end

  // Pinned literal expectations, written just after a posedge by the
  // stimulus process and read at the following negedge.
  bit       chk_on    = 0;
  bit       pin_on    = 0;
  bit       pin_valid = 0;
  int       pin_idx   = 0;
  int       pin_count = 0;
  string    pin_name  = "";

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h want %0h", name, $time, got, want);
    end
  endtask

  always @(negedge clock) begin
    if (chk_on) begin
      logic [N-1:0] m_gnt;
      m_gnt = '0;
      if (m_valid == 1) m_gnt[m_idx] = 1'b1;
      chk("gnt", int'(gnt), int'(m_gnt));
      chk("gnt_valid", int'(gnt_valid), m_valid);
      chk("gnt_idx", int'(gnt_idx), m_idx);
      chk("count", int'(count), m_count);
      chk("onehot", int'($countones(gnt) <= 1), 1);
      if (pin_on) begin
        chk({pin_name, ".valid"}, int'(gnt_valid), int'(pin_valid));
        chk({pin_name, ".idx"}, int'(gnt_idx), pin_idx);
        chk({pin_name, ".count"}, int'(count), pin_count);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #2;
    pin_on = 0;
  endtask

  task automatic tick_pin(input string name, input bit v, input int idx, input int cnt);
    @(posedge clock);
    #2;
    pin_on = 1; pin_name = name; pin_valid = v; pin_idx = idx; pin_count = cnt;
  endtask

  initial begin
    // Reset.
    reset_n = 1'b0; en = 1'b1; req = 8'hFF;
    tick_pin("reset", 0, 0, 0);
    chk_on = 1;

    // Full request sweep: 0..7 then 0, pointer 1..7,0,1.
    reset_n = 1'b1; en = 1'b1; req = 8'hFF;
    for (int j = 0; j < 9; j++) tick_pin("sweep", 1, j % N, (j + 1) % N);

    // Advance pointer to 6.
    for (int j = 1; j < 6; j++) tick_pin("adv", 1, j, j + 1);

    // count=6, req=05 -> idx 0 count 1, then idx 2 count 3.
    req = 8'h05;
    tick_pin("wrap0", 1, 0, 1);
    tick_pin("wrap2", 1, 2, 3);

    // Bring pointer to 4, then disable for three cycles.
    req = 8'h08;
    tick_pin("to4", 1, 3, 4);
    en = 1'b0; req = 8'hFF;
    for (int j = 0; j < 3; j++) tick_pin("dis", 0, 0, 4);
    en = 1'b1;
    tick_pin("reen", 1, 4, 5);

    // Enabled with no requests: idle, pointer held.
    req = 8'h00;
    tick_pin("noreq", 0, 0, 5);

    // Single requester granted every cycle regardless of pointer.
    req = 8'h02;
    for (int j = 0; j < 3; j++) tick_pin("single", 1, 1, 2);

`ifdef RPS_LOCK_EN
    // Lock on idx 3 for 4 cycles, then release.
    req = 8'h08;
    tick_pin("lk3", 1, 3, 4);
    lock = 1'b1; req = 8'hFF;
    for (int j = 0; j < 4; j++) tick_pin("lkhold", 1, 3, 4);
    lock = 1'b0;
    tick_pin("lkrel", 1, 4, 5);

    // Release by dropping the holder's request: no idle cycle.
    req = 8'h08;
    tick_pin("lk3b", 1, 3, 4);
    lock = 1'b1; req = 8'hFF;
    tick_pin("lkhold2", 1, 3, 4);
    req = 8'hF7;
    tick_pin("reqdrop", 1, 4, 5);

    // Lock with no grant has no effect.
    en = 1'b0;
    tick_pin("lkidle", 0, 0, 5);
    en = 1'b1; req = 8'hFF;
    tick_pin("lknogrant", 1, 5, 6);

    // Reset mid-lock on idx 5.
    lock = 1'b0; req = 8'h20;
    tick_pin("lk5", 1, 5, 6);
    lock = 1'b1; req = 8'hFF;
    tick_pin("lk5hold", 1, 5, 6);
`else
    req = 8'h20;
    tick_pin("g5", 1, 5, 6);
`endif
    reset_n = 1'b0;
    tick_pin("midrst", 0, 0, 0);
    reset_n = 1'b1; req = 8'hFF;
    tick_pin("postrst", 1, 0, 1);

    // Randomized traffic checked against the model.
    for (int j = 0; j < 3000; j++) begin
      case ($urandom_range(0, 3))
        0: req = '0;
        1: req = N'(1) << $urandom_range(0, N - 1);
        2: req = N'($urandom);
        default: req = 8'hFF;
      endcase
      en = ($urandom_range(0, 9) != 0);
      reset_n = ($urandom_range(0, 49) != 0);
`ifdef RPS_LOCK_EN
      lock = $urandom_range(0, 1) == 1;
`endif
      tick();
    end

    reset_n = 1'b1; en = 1'b0;
    tick();
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
